// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// bits_per_cycle bits retired per iteration, start/busy/done handshake with kill.
module muldiv_unit #(
  parameter int data_bits      = 32,
  parameter int bits_per_cycle = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 kill,
  input  logic [2:0]           func_3_bits,
  input  logic [data_bits-1:0] operand_a,
  input  logic [data_bits-1:0] operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [data_bits-1:0] result
);

  localparam int W    = data_bits;
  localparam int ITER = data_bits / bits_per_cycle;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     f3_q, f3_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;

  logic           sgn_a, sgn_b;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] mul_next, div_next, prod_raw, prod_fix;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  // One multiplier bit: conditionally add the multiplicand into the high half, shift right.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : {(W+1){1'b0}});
    return {s, p[W-1:1]};
  endfunction

  // One quotient bit: {remainder, dividend} shifts left, quotient bit enters at the bottom.
  function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] p, input logic [W-1:0] d);
    logic [W:0] r;
    logic       qb;
    r  = {p[2*W-1:W], p[W-1]};
    qb = (r >= {1'b0, d});
    if (qb) r = r - {1'b0, d};
    return {r[W-1:0], p[W-2:0], qb};
  endfunction

  function automatic logic [2*W-1:0] mul_iter(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [2*W-1:0] t;
    t = p;
    for (int i = 0; i < bits_per_cycle; i++) t = mul_step(t, m);
    return t;
  endfunction

  function automatic logic [2*W-1:0] div_iter(input logic [2*W-1:0] p, input logic [W-1:0] d);
    logic [2*W-1:0] t;
    t = p;
    for (int i = 0; i < bits_per_cycle; i++) t = div_step(t, d);
    return t;
  endfunction

  // MUL (000) is treated as unsigned: the low half of the product is sign-agnostic.
  assign sgn_a = operand_a[W-1] &&
                 (func_3_bits inside {3'b001, 3'b010, 3'b100, 3'b110});
  assign sgn_b = operand_b[W-1] &&
                 (func_3_bits inside {3'b001, 3'b100, 3'b110});
  assign mag_a = mag(operand_a, sgn_a);
  assign mag_b = mag(operand_b, sgn_b);

  assign mul_next = mul_iter({hi_q, lo_q}, opnd_q);
  assign div_next = div_iter({hi_q, lo_q}, opnd_q);
  assign prod_raw = {hi_q, lo_q};
  assign prod_fix = negq_q ? (~prod_raw + 1'b1) : prod_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        // The done cycle is still an IDLE cycle but must not accept a new request.
        if (start && !kill && !done_q) begin
          f3_d   = func_3_bits;
          busy_d = 1'b1;
          cnt_d  = CW'(ITER);
          hi_d   = '0;
          if (!func_3_bits[2]) begin
            lo_d    = mag_b;
            opnd_d  = mag_a;
            negq_d  = sgn_a ^ sgn_b;
            negr_d  = 1'b0;
            state_d = S_MUL;
          end else if (operand_b == '0) begin
            // Preload the accumulators so FIN yields the divide-by-zero results unchanged.
            hi_d    = operand_a;
            lo_d    = '1;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_FIN;
          end else if (!func_3_bits[0] && operand_a == {1'b1, {(W-1){1'b0}}} &&
                       operand_b == '1) begin
            lo_d    = operand_a;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            lo_d    = mag_a;
            opnd_d  = mag_b;
            negq_d  = sgn_a ^ sgn_b;
            negr_d  = sgn_a;
            state_d = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (kill) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          {hi_d, lo_d} = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d        = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!kill) begin
          done_d = 1'b1;
          case (f3_q)
            3'b000:                 result_d = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*W-1:W];
            3'b100, 3'b101:         result_d = negq_q ? (~lo_q + 1'b1) : lo_q;
            default:                result_d = negr_q ? (~hi_q + 1'b1) : hi_q;
          endcase
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit at radix 1 and radix 4 against a
// plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start1, start4, kill;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;
  int          ncmp = 0;
  int          nfail = 0;

  localparam logic [31:0] MIN = 32'h8000_0000;

  muldiv_unit #(.data_bits(32), .bits_per_cycle(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .kill(kill), .func_3_bits(f3),
    .operand_a(a), .operand_b(b), .busy(busy1), .done(done1), .result(res1));

  muldiv_unit #(.data_bits(32), .bits_per_cycle(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .kill(kill), .func_3_bits(f3),
    .operand_a(a), .operand_b(b), .busy(busy4), .done(done4), .result(res4));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [63:0] sx, sy, ps;
    logic [63:0]        pu;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    case (fn)
      3'b000: begin pu = {32'b0, x} * {32'b0, y}; return pu[31:0]; end
      3'b001: begin ps = sx * sy; return ps[63:32]; end
      3'b010: begin ps = sx * $signed({32'b0, y}); return ps[63:32]; end
      3'b011: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN && y == 32'hFFFF_FFFF) return MIN;
        return $signed(x) / $signed(y);
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == MIN && y == 32'hFFFF_FFFF) return 32'h0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Runs one operation on both radices at once and checks result, latency, busy span, done pulse.
  task automatic do_op(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] exp_r, r1, r4;
    int          lat1, lat4, nb, nd;
    bit          fast;
    exp_r = ref_model(fn, x, y);
    fast  = fn[2] && (y == 0 || (!fn[0] && x == MIN && y == 32'hFFFF_FFFF));
    lat1 = -1; lat4 = -1; nb = 0; nd = 0; r1 = 'x; r4 = 'x;
    @(negedge clk);
    f3 = fn; a = x; b = y; start1 = 1'b1; start4 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      f3 = 3'($urandom); a = $urandom; b = $urandom;
      if (busy1) nb++;
      if (done1) begin nd++; if (lat1 < 0) begin lat1 = c; r1 = res1; end end
      if (done4) begin nd++; if (lat4 < 0) begin lat4 = c; r4 = res4; end end
    end
    check($sformatf("result_r1 f%0d", fn), r1, exp_r);
    check($sformatf("result_r4 f%0d", fn), r4, exp_r);
    check($sformatf("latency_r1 f%0d", fn), 32'(lat1), fast ? 32'd2 : 32'd34);
    check($sformatf("latency_r4 f%0d", fn), 32'(lat4), fast ? 32'd2 : 32'd10);
    check($sformatf("busy_span f%0d", fn), 32'(nb), fast ? 32'd1 : 32'd33);
    check($sformatf("done_pulses f%0d", fn), 32'(nd), 32'd2);
    check($sformatf("result_hold f%0d", fn), res1, exp_r);
  endtask

  initial begin
    logic [31:0] prior, x, y;
    logic [2:0]  fn;
    int          nd, waited;

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; kill = 1'b0;
    f3 = '0; a = '0; b = '0;
    #12;
    check("reset_busy", {30'b0, busy1, busy4}, 32'h0);
    check("reset_done", {30'b0, done1, done4}, 32'h0);
    check("reset_result1", res1, 32'h0);
    check("reset_result4", res4, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    do_op(3'b001, MIN, 32'hFFFF_FFFF);
    do_op(3'b010, MIN, 32'hFFFF_FFFF);
    do_op(3'b011, MIN, 32'hFFFF_FFFF);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b101, 32'd100, 32'd7);
    do_op(3'b111, 32'd100, 32'd7);
    do_op(3'b101, 32'd5, 32'd0);
    do_op(3'b110, 32'd5, 32'd0);
    do_op(3'b100, MIN, 32'hFFFF_FFFF);
    do_op(3'b110, MIN, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      fn = 3'($urandom);
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: begin x = MIN; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 300) - 150; y = $urandom_range(0, 20) - 10; end
        default: ;
      endcase
      do_op(fn, x, y);
    end

    // start while busy is ignored; start in the done cycle is not accepted
    @(negedge clk);
    f3 = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD; start1 = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      start1 = (waited == 5);
      if (waited == 5) begin f3 = 3'b101; a = 32'd100; b = 32'd7; end
    end while (!done1 && waited < 40);
    check("busy_restart_latency", 32'(waited), 32'd34);
    check("busy_restart_result", res1, 32'hFFFF_FFEB);
    start1 = 1'b1; f3 = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start1 = 1'b0;
    check("done_cycle_start_busy", {31'b0, busy1}, 32'h0);
    @(negedge clk);
    check("done_cycle_start_busy2", {31'b0, busy1}, 32'h0);
    check("done_cycle_start_result", res1, 32'hFFFF_FFEB);

    // kill at cycle 10 of a divide
    prior = res1;
    @(negedge clk);
    f3 = 3'b100; a = 32'd12345; b = 32'd7; start1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      kill = (c == 10);
    end
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy1}, 32'h0);
    check("kill_done", {31'b0, done1}, 32'h0);
    check("kill_result", res1, prior);
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    check("kill_no_done", 32'(nd), 32'h0);

    // kill and start together in IDLE: nothing accepted
    start1 = 1'b1; kill = 1'b1;
    @(negedge clk);
    start1 = 1'b0; kill = 1'b0;
    check("kill_start_idle", {31'b0, busy1}, 32'h0);

    // asynchronous reset mid-divide
    do_op(3'b101, 32'd1000, 32'd3);
    @(negedge clk);
    f3 = 3'b100; a = 32'd999; b = 32'd4; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", {31'b0, busy1}, 32'h0);
    check("async_reset_done", {31'b0, done1}, 32'h0);
    check("async_reset_result1", res1, 32'h0);
    check("async_reset_result4", res4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
